// File: rtl/word_uart_tx.sv
// Serialises wide words from a FIFO onto a UART line, DATA_WIDTH-bit characters
// sent low character first, 8N1-style framing (start, data LSB first, one stop).
module word_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_WIDTH = 256,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  check_empty,
  output logic                  read_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  word_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int NUM_BYTES    = WORD_WIDTH / DATA_WIDTH;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int BYTE_W       = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        baud_cnt;
  logic [BIT_W-1:0]        bit_idx;
  logic [BYTE_W-1:0]       byte_idx;
  logic [WORD_WIDTH-1:0]   word_sr;
  logic                    baud_last;

  assign baud_last = (baud_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      read_enable <= 1'b0;
      busy        <= 1'b0;
      word_done   <= 1'b0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
    end else begin
      read_enable <= 1'b0;
      word_done   <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (!check_empty) begin
            state       <= FETCH;
            read_enable <= 1'b1;
            busy        <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          state    <= START;
          tx       <= 1'b0;
          byte_idx <= '0;
          bit_idx  <= '0;
        end
        START: begin
          if (baud_last) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= word_sr[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // word_sr shifts on this same edge, so bit 1 is the next bit out
              tx      <= word_sr[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (byte_idx != BYTE_LAST) begin
              state    <= START;
              byte_idx <= byte_idx + 1'b1;
              tx       <= 1'b0;
            end else begin
              state     <= IDLE;
              word_done <= 1'b1;
              busy      <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Word shift register: loaded once per word, shifted one bit per data bit sent.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      word_sr <= data_in;
    end else if (state == DATA && baud_last) begin
      word_sr <= word_sr >> 1;
    end
  end

endmodule

// File: tb/tb_word_uart_tx.sv
// Bench for word_uart_tx: FIFO model, line decoder with byte scoreboard, and
// hand-written sequences for reset, idle and back-to-back behaviour.
module tb_word_uart_tx;

  localparam int DW   = 8;
  localparam int WW   = 16;
  localparam int CLKF = 1_000_000;
  localparam int BAUD = 100_000;
  localparam int CPB  = CLKF / BAUD;

  typedef struct {
    logic [WW-1:0] word;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
  } vec_t;

  typedef struct {
    logic [DW-1:0] b;
    int            gap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WW-1:0] data_in = '0;
  logic          check_empty = 1'b1;
  logic          read_enable;
  logic          tx;
  logic          busy;
  logic          word_done;

  logic [WW-1:0] fifo_q[$];
  exp_t          sb_q[$];
  logic          toggle_mode = 1'b0;
  logic          mon_en = 1'b0;

  int cyc = 0;
  int rd_cnt = 0;
  int wd_cnt = 0;
  int last_wd_cyc = 0;
  int overlap_cnt = 0;
  int wd_target = 0;
  int frame_cnt = 0;
  int start_log[64];
  int pass_cnt = 0;
  int total_cnt = 0;

  word_uart_tx #(
    .DATA_WIDTH(DW),
    .WORD_WIDTH(WW),
    .CLK_FREQ  (CLKF),
    .BAUD_RATE (BAUD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .check_empty(check_empty),
    .read_enable(read_enable),
    .tx         (tx),
    .busy       (busy),
    .word_done  (word_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  // FIFO model: data valid the cycle after the read strobe.
  always @(negedge clk) begin
    if (read_enable === 1'b1) begin
      rd_cnt++;
      if (fifo_q.size() > 0) data_in = fifo_q.pop_front();
    end
    if (toggle_mode && busy === 1'b1) check_empty = ~check_empty;
    else check_empty = (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (word_done === 1'b1) begin
      wd_cnt++;
      last_wd_cyc = cyc;
      if (read_enable === 1'b1) overlap_cnt++;
    end
  end

  // Line decoder: samples every cycle of a frame, pops the scoreboard at the stop bit.
  initial begin : line_monitor
    logic [9:0] bits;
    int         glitch;
    int         st;
    int         prev_end;
    exp_t       e;
    prev_end = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst && tx === 1'b0) begin
        st = cyc;
        glitch = 0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) bits[b] = tx;
            else if (tx !== bits[b]) glitch++;
          end
        end
        if (frame_cnt < 64) start_log[frame_cnt] = st;
        frame_cnt++;
        chk("frame_stable", glitch, 0);
        chk("frame_stop", {31'd0, bits[9]}, 1);
        chk("frame_expected", {31'd0, sb_q.size() > 0}, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("frame_byte", {24'd0, bits[8:1]}, {24'd0, e.b});
          if (e.gap != 0) chk("frame_gap", st - prev_end, e.gap);
        end
        prev_end = cyc;
      end
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || wd_cnt < wd_target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bound", {31'd0, n < budget}, 1);
    repeat (20) @(negedge clk);
  endtask

  initial begin : main
    vec_t vecs[5];
    int   rd0;
    int   f0;
    int   wd0;
    int   bad_tx;
    int   bad_busy;
    int   n;

    vecs[0] = '{word: 16'h0000, b0: 8'h00, b1: 8'h00};
    vecs[1] = '{word: 16'hFFFF, b0: 8'hFF, b1: 8'hFF};
    vecs[2] = '{word: 16'h1234, b0: 8'h34, b1: 8'h12};
    vecs[3] = '{word: 16'h8001, b0: 8'h01, b1: 8'h80};
    vecs[4] = '{word: 16'h6BD2, b0: 8'hD2, b1: 8'h6B};

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_read_enable", {31'd0, read_enable}, 0);
    chk("rst_word_done", {31'd0, word_done}, 0);
    rst = 1'b1;

    // Empty FIFO held: nothing must move.
    bad_tx = 0;
    bad_busy = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
      if (busy !== 1'b0) bad_busy++;
    end
    chk("idle_tx_high", bad_tx, 0);
    chk("idle_busy_low", bad_busy, 0);
    chk("idle_no_read", rd_cnt, 0);

    // Single word A53C.
    mon_en = 1'b1;
    rd0 = rd_cnt;
    f0 = frame_cnt;
    wd0 = wd_cnt;
    sb_q.push_back('{b: 8'h3C, gap: 0});
    sb_q.push_back('{b: 8'hA5, gap: 1});
    wd_target++;
    fifo_q.push_back(16'hA53C);
    wait_done(1000);
    chk("single_reads", rd_cnt - rd0, 1);
    chk("single_word_done", wd_cnt - wd0, 1);
    chk("single_wd_latency", last_wd_cyc - start_log[f0], 200);

    // Two queued words: 3 idle-high cycles between words.
    rd0 = rd_cnt;
    sb_q.push_back('{b: 8'h01, gap: 0});
    sb_q.push_back('{b: 8'h00, gap: 1});
    sb_q.push_back('{b: 8'h80, gap: 4});
    sb_q.push_back('{b: 8'hFF, gap: 1});
    wd_target += 2;
    fifo_q.push_back(16'h0001);
    fifo_q.push_back(16'hFF80);
    wait_done(2000);
    chk("b2b_reads", rd_cnt - rd0, 2);

    // Table of words sent back to back.
    rd0 = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{b: vecs[i].b0, gap: (i == 0) ? 0 : 4});
      sb_q.push_back('{b: vecs[i].b1, gap: 1});
      wd_target++;
      fifo_q.push_back(vecs[i].word);
    end
    wait_done(4000);
    chk("table_reads", rd_cnt - rd0, 5);

    // check_empty toggling while busy is ignored.
    rd0 = rd_cnt;
    toggle_mode = 1'b1;
    sb_q.push_back('{b: 8'h6E, gap: 0});
    sb_q.push_back('{b: 8'h9C, gap: 1});
    wd_target++;
    fifo_q.push_back(16'h9C6E);
    wait_done(1000);
    toggle_mode = 1'b0;
    chk("toggle_reads", rd_cnt - rd0, 1);

    // Reset during bit 4 of the second character.
    mon_en = 1'b0;
    rd0 = rd_cnt;
    wd0 = wd_cnt;
    fifo_q.push_back(16'hA53C);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_frame_started", {31'd0, n < 100}, 1);
    repeat (153) @(negedge clk);
    chk("midframe_busy", {31'd0, busy}, 1);
    chk("midframe_bit4", {31'd0, tx}, 0);
    rst = 1'b0;
    #1;
    chk("midrst_tx", {31'd0, tx}, 1);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_read_enable", {31'd0, read_enable}, 0);
    @(negedge clk);
    rst = 1'b1;
    bad_tx = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) bad_tx++;
    end
    chk("postrst_tx_high", bad_tx, 0);
    chk("postrst_reads", rd_cnt - rd0, 1);
    chk("postrst_no_word_done", wd_cnt - wd0, 0);

    // A fresh word after reset is fetched and sent normally.
    mon_en = 1'b1;
    rd0 = rd_cnt;
    sb_q.push_back('{b: 8'h55, gap: 0});
    sb_q.push_back('{b: 8'h0F, gap: 1});
    wd_target++;
    fifo_q.push_back(16'h0F55);
    wait_done(1000);
    chk("resume_reads", rd_cnt - rd0, 1);

    chk("word_done_read_overlap", overlap_cnt, 0);
    chk("total_frames", frame_cnt, 20);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
